// File: rtl/team_06_pkg.sv
// Shared types and constants for the ADC SPI capture stage.
package team_06_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} adc_state_t;

  localparam int AUDIO_W = 8;
  localparam logic [AUDIO_W-1:0] AUDIO_MID = 8'h80;

  // Bit counter must hold 0..adc_bits (null bit plus data bits).
  function automatic int bit_cnt_w(input int adc_bits);
    return $clog2(adc_bits + 2);
  endfunction

  function automatic int frame_len(input int sclk_div, input int adc_bits);
    return sclk_div * (2 * (adc_bits + 1) + 2) + 1;
  endfunction

endpackage

// File: rtl/team_06_sclk_gen.sv
// SCLK half-period divider: tick per half period, rise/fall strobes, bit counter.
module team_06_sclk_gen
  import team_06_pkg::*;
#(
  parameter int SCLK_DIV = 4,
  parameter int ADC_BITS = 10,
  localparam int BIT_W   = bit_cnt_w(ADC_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             shift,
  output logic             tick,
  output logic             rise,
  output logic             fall,
  output logic             last,
  output logic             sclk,
  output logic [BIT_W-1:0] bit_cnt
);

  localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = active && (cnt == CNT_W'(SCLK_DIV - 1));
  assign rise = shift && tick && !sclk;
  assign fall = shift && tick && sclk;
  assign last = fall && (bit_cnt == BIT_W'(ADC_BITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // sclk is a flop so the ADC never sees a combinational glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk <= 1'b0;
    end else if (!shift) begin
      sclk <= 1'b0;
    end else if (tick) begin
      sclk <= ~sclk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (!shift) begin
      bit_cnt <= '0;
    end else if (fall) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/team_06_adc_spi_rx.sv
// Periodic 10-bit serial ADC reader producing 8-bit unsigned audio samples.
module team_06_adc_spi_rx
  import team_06_pkg::*;
#(
  parameter int SCLK_DIV      = 4,
  parameter int SAMPLE_PERIOD = 256,
  parameter int ADC_BITS      = 10
) (
  input  logic               clkdiv,
  input  logic               rst,
  input  logic               enable,
  input  logic               adc_miso,
  output logic               adc_sclk,
  output logic               adc_cs_n,
  output logic [AUDIO_W-1:0] audio_out,
  output logic               sample_valid,
  output logic               busy
);

  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int BIT_W = bit_cnt_w(ADC_BITS);

  adc_state_t          state, state_next;
  logic [PER_W-1:0]    per_cnt;
  logic                wrap, start;
  logic [ADC_BITS-1:0] shift_reg;
  logic                active, shifting;
  logic                tick, rise, fall, last;
  logic [BIT_W-1:0]    bit_cnt;

  assign wrap     = (per_cnt == PER_W'(SAMPLE_PERIOD - 1));
  assign start    = enable && wrap && (state == IDLE);
  assign active   = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign shifting = (state == SHIFT);
  assign busy     = (state != IDLE);

  team_06_sclk_gen #(
    .SCLK_DIV (SCLK_DIV),
    .ADC_BITS (ADC_BITS)
  ) u_sclk_gen (
    .clk     (clkdiv),
    .rst     (rst),
    .active  (active),
    .shift   (shifting),
    .tick    (tick),
    .rise    (rise),
    .fall    (fall),
    .last    (last),
    .sclk    (adc_sclk),
    .bit_cnt (bit_cnt)
  );

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (!enable || wrap) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (tick)  state_next = SHIFT;
      SHIFT:   if (last)  state_next = HOLD;
      HOLD:    if (tick)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cs_n is registered from the next state so it switches with the state flop.
  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      adc_cs_n <= 1'b1;
    end else begin
      adc_cs_n <= !((state_next == SETUP) || (state_next == SHIFT) ||
                    (state_next == HOLD));
    end
  end

  // The first rising edge of a frame carries the ADC null bit; skip it.
  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (state == SETUP) begin
      shift_reg <= '0;
    end else if (rise && (bit_cnt != '0)) begin
      shift_reg <= {shift_reg[ADC_BITS-2:0], adc_miso};
    end
  end

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      audio_out    <= AUDIO_MID;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == DONE);
      if (state == DONE) begin
        audio_out <= shift_reg[ADC_BITS-1 -: AUDIO_W];
      end
    end
  end

  start_while_busy : assert property (@(posedge clkdiv) disable iff (rst)
    !(enable && wrap && busy));

endmodule

// File: tb/tb_team_06_adc_spi_rx.sv
// Directed bench for team_06_adc_spi_rx with a behavioural serial ADC.
module tb_team_06_adc_spi_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       adc_miso;
  logic       adc_sclk;
  logic       adc_cs_n;
  logic [7:0] audio_out;
  logic       sample_valid;
  logic       busy;
  logic [7:0] trem_audio_in;

  logic [9:0]  adc_word;
  logic [10:0] frame_bits;
  int          bit_idx = 10;
  logic        armed = 1'b1;

  int passes = 0;
  int total  = 0;

  int cyc = 0;
  int cs_falls = 0, cs_fall_cyc = 0;
  int rises = 0, hi_run = 0, hi_min = 1000, hi_max = 0;
  int sv_count = 0, sv_cyc = 0, prev_sv_cyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  int cyc_en, base;

  always #10 clk = ~clk;

  team_06_adc_spi_rx #(
    .SCLK_DIV      (4),
    .SAMPLE_PERIOD (256),
    .ADC_BITS      (10)
  ) dut (
    .clkdiv       (clk),
    .rst          (rst),
    .enable       (enable),
    .adc_miso     (adc_miso),
    .adc_sclk     (adc_sclk),
    .adc_cs_n     (adc_cs_n),
    .audio_out    (audio_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  assign trem_audio_in = audio_out;

  // ADC: null bit (0) presented at cs_n fall, next bit after each sclk fall.
  assign frame_bits = {1'b0, adc_word};
  assign adc_miso   = frame_bits[bit_idx];

  always @(posedge adc_cs_n or negedge adc_cs_n or negedge adc_sclk) begin
    if (adc_cs_n) begin
      bit_idx = 10;
      armed   = 1'b1;
    end else if (armed) begin
      armed = 1'b0;
    end else if (bit_idx > 0) begin
      bit_idx--;
    end
  end

  // Event recorder: cyc is the index of the most recent rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (prev_cs && !adc_cs_n) begin
      cs_falls++;
      cs_fall_cyc = cyc;
      rises  = 0;
      hi_min = 1000;
      hi_max = 0;
    end
    if (!prev_sclk && adc_sclk) rises++;
    if (adc_sclk) begin
      hi_run++;
    end else if (hi_run != 0) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
    if (sample_valid) begin
      sv_count++;
      prev_sv_cyc = sv_cyc;
      sv_cyc      = cyc;
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    total++;
    assert (observed === expected) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic wait_cs_fall(input int bound, input string tag);
    int b = cs_falls;
    int n = 0;
    while (cs_falls == b && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(cs_falls != b), 32'd1);
  endtask

  task automatic wait_sv(input int bound, input string tag);
    int b = sv_count;
    int n = 0;
    while (sv_count == b && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sv_count != b), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    adc_word = 10'h000;
    #15;
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd0);
    chk("rst_audio", 32'(audio_out), 32'h80);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #10;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_cs_n", 32'(adc_cs_n), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_audio", 32'(audio_out), 32'h80);

    // Single conversion
    adc_word = 10'h2A5;
    enable   = 1'b1;
    cyc_en   = cyc + 1;
    wait_cs_fall(300, "first_start_timeout");
    chk("first_start_delay", 32'(cs_fall_cyc - cyc_en), 32'd255);
    chk("busy_in_frame", 32'(busy), 32'd1);
    wait_sv(150, "sv1_timeout");
    chk("latency", 32'(sv_cyc - cs_fall_cyc), 32'd97);
    chk("audio_2a5", 32'(audio_out), 32'hA9);
    chk("sclk_rises", 32'(rises), 32'd11);
    chk("sclk_hi_min", 32'(hi_min), 32'd4);
    chk("sclk_hi_max", 32'(hi_max), 32'd4);
    chk("cs_n_after", 32'(adc_cs_n), 32'd1);
    @(negedge clk);
    chk("valid_one_cycle", 32'(sample_valid), 32'd0);
    chk("audio_held", 32'(audio_out), 32'hA9);

    // Extremes
    adc_word = 10'h3FF;
    wait_sv(300, "sv_ff_timeout");
    chk("audio_3ff", 32'(audio_out), 32'hFF);
    chk("interval_ff", 32'(sv_cyc - prev_sv_cyc), 32'd256);
    adc_word = 10'h000;
    wait_sv(300, "sv_00_timeout");
    chk("audio_000", 32'(audio_out), 32'h00);
    chk("interval_00", 32'(sv_cyc - prev_sv_cyc), 32'd256);

    // Enable dropped 40 cycles into a frame
    adc_word = 10'h155;
    wait_cs_fall(300, "start_drop_timeout");
    repeat (40) @(negedge clk);
    enable = 1'b0;
    wait_sv(100, "sv_drop_timeout");
    chk("audio_155", 32'(audio_out), 32'h55);
    chk("latency_drop", 32'(sv_cyc - cs_fall_cyc), 32'd97);
    base = cs_falls;
    repeat (1000) @(negedge clk);
    chk("no_start_disabled", 32'(cs_falls), 32'(base));
    chk("idle_disabled", 32'(busy), 32'd0);
    enable = 1'b1;
    cyc_en = cyc + 1;
    wait_cs_fall(300, "restart_timeout");
    chk("restart_delay", 32'(cs_fall_cyc - cyc_en), 32'd255);

    // Reset 50 cycles into the frame (sclk is high at that point)
    repeat (50) @(negedge clk);
    chk("sclk_hi_pre_rst", 32'(adc_sclk), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("mid_rst_sclk", 32'(adc_sclk), 32'd0);
    chk("mid_rst_audio", 32'(audio_out), 32'h80);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    base = sv_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("no_sv_after_rst", 32'(sv_count), 32'(base));
    chk("audio_after_rst", 32'(audio_out), 32'h80);

    // Downstream hookup: tremolo audio_in follows audio_out
    adc_word = 10'h190;
    wait_sv(400, "sv_trem_timeout");
    chk("trem_in_first", 32'(trem_audio_in), 32'd100);
    wait_sv(300, "sv_trem2_timeout");
    chk("trem_in_steady", 32'(trem_audio_in), 32'd100);
    chk("interval_trem", 32'(sv_cyc - prev_sv_cyc), 32'd256);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
